// File: rtl/alu_pkg.sv
// ALU issue package: control codes, decoded alu_op encoding,
// issue packet layout and the issue buffer state encoding.
package alu_pkg;

    // Operand width carried in the issue packet.
    localparam int ISSUE_XLEN = 32;

    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_XOR     = 4'b0100;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

    typedef enum logic [1:0] {
        LDST   = 2'b00,
        BRANCH = 2'b01,
        RTYPE  = 2'b10,
        ITYPE  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } issue_state_e;

    typedef struct packed {
        logic [3:0]            control;
        logic [ISSUE_XLEN-1:0] in1;
        logic [ISSUE_XLEN-1:0] in2;
        logic                  is_branch;
        logic                  illegal;
    } issue_pkt_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decoder.
// In: alu_op_i, funct3_i, funct7_5_i. Out: control_o, is_branch_o, illegal_o.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    output logic [3:0] control_o,
    output logic       is_branch_o,
    output logic       illegal_o
);

    alu_op_e op;
    assign op = alu_op_e'(alu_op_i);

    always_comb begin
        control_o   = ALU_ADD;
        is_branch_o = 1'b0;
        illegal_o   = 1'b0;
        unique case (op)
            LDST: control_o = ALU_ADD;
            BRANCH: begin
                control_o   = ALU_SUB;
                is_branch_o = 1'b1;
            end
            RTYPE, ITYPE: begin
                unique case (funct3_i)
                    // funct7[5] selects SUB only for register forms;
                    // for immediates bit 30 is part of the immediate.
                    3'b000: control_o = (op == RTYPE && funct7_5_i)
                                        ? ALU_SUB : ALU_ADD;
                    3'b100: control_o = ALU_XOR;
                    3'b110: control_o = ALU_OR;
                    3'b111: control_o = ALU_AND;
                    default: begin
                        control_o = ALU_ILLEGAL;
                        illegal_o = 1'b1;
                    end
                endcase
            end
            default: begin
                control_o = ALU_ILLEGAL;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes ALU control, selects operands and buffers
// them in a 2-entry head/skid queue. Ports: decode-side in_valid/in_ready
// with instruction fields, EX-side out_valid/out_ready with head packet.
module alu_issue_stage
    import alu_pkg::*;
#(
    // Must equal alu_pkg::ISSUE_XLEN; the packet is sized by the package.
    parameter int XLEN = ISSUE_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            use_imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      control_o,
    output logic [XLEN-1:0] in1_o,
    output logic [XLEN-1:0] in2_o,
    output logic            is_branch_o,
    output logic            illegal_o
);

    issue_state_e state_q, state_d;
    issue_pkt_t   head_q, head_d;
    issue_pkt_t   skid_q, skid_d;
    logic         rdy_q, rdy_d;

    issue_pkt_t   pkt_in;
    logic         accept;
    logic         pop;

    alu_ctrl_decode u_dec (
        .alu_op_i    (alu_op),
        .funct3_i    (funct3),
        .funct7_5_i  (funct7_5),
        .control_o   (pkt_in.control),
        .is_branch_o (pkt_in.is_branch),
        .illegal_o   (pkt_in.illegal)
    );

    assign pkt_in.in1 = rs1_data;
    assign pkt_in.in2 = use_imm ? imm : rs2_data;

    assign accept = in_valid && rdy_q;
    assign pop    = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        head_d  = pkt_in;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && !pop) begin
                        skid_d  = pkt_in;
                        state_d = ST_FULL;
                    end else if (accept && pop) begin
                        head_d = pkt_in;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        head_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        // Ready is registered from the next state so decode never sees
        // a combinational path from out_ready.
        rdy_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
        end
    end

    assign in_ready    = rdy_q;
    assign out_valid   = (state_q != ST_EMPTY);
    assign control_o   = head_q.control;
    assign in1_o       = head_q.in1;
    assign in2_o       = head_q.in2;
    assign is_branch_o = head_q.is_branch;
    assign illegal_o   = head_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage.
// Directed scenarios plus a randomized run against a queue model.
module tb_alu_issue_stage;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic            use_imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      control_o;
    logic [XLEN-1:0] in1_o;
    logic [XLEN-1:0] in2_o;
    logic            is_branch_o;
    logic            illegal_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]      code;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic            br;
        logic            ill;
    } exp_t;

    exp_t exp_q[$];
    logic m_ready;

    alu_issue_stage #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .use_imm     (use_imm),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .imm         (imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .control_o   (control_o),
        .in1_o       (in1_o),
        .in2_o       (in2_o),
        .is_branch_o (is_branch_o),
        .illegal_o   (illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t ref_pkt();
        exp_t r;
        r.br  = (alu_op == 2'd1);
        r.a   = rs1_data;
        r.b   = use_imm ? imm : rs2_data;
        if (alu_op == 2'd0)
            r.code = 4'b0010;
        else if (alu_op == 2'd1)
            r.code = 4'b0110;
        else begin
            case (funct3)
                3'd0: r.code = (alu_op == 2'd2 && funct7_5)
                               ? 4'b0110 : 4'b0010;
                3'd4: r.code = 4'b0100;
                3'd6: r.code = 4'b0001;
                3'd7: r.code = 4'b0000;
                default: r.code = 4'b1111;
            endcase
        end
        r.ill = (r.code == 4'b1111);
        return r;
    endfunction

    // Advance one clock with the currently driven inputs and update
    // the model; returns at the following falling edge.
    task automatic tick();
        logic acc, pp;
        exp_t e, d;
        acc = in_valid && m_ready;
        pp  = (exp_q.size() > 0) && out_ready;
        e   = ref_pkt();
        @(posedge clk);
        if (flush) begin
            exp_q.delete();
        end else begin
            if (pp) d = exp_q.pop_front();
            if (acc) exp_q.push_back(e);
        end
        m_ready = (exp_q.size() < 2);
        @(negedge clk);
    endtask

    task automatic set_fields(input logic [1:0] op, input logic [2:0] f3,
                              input logic f7, input logic ui,
                              input logic [XLEN-1:0] a,
                              input logic [XLEN-1:0] b,
                              input logic [XLEN-1:0] im);
        alu_op   = op;
        funct3   = f3;
        funct7_5 = f7;
        use_imm  = ui;
        rs1_data = a;
        rs2_data = b;
        imm      = im;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_fields(2'd0, 3'd0, 1'b0, 1'b0, '0, '0, '0);
        m_ready = 1'b0;
        #12;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_ready got=%b want=0", in_ready);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        total++;
        if (control_o !== 4'b0000 || in1_o !== '0 || in2_o !== '0
            || is_branch_o !== 1'b0 || illegal_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_data ctl=%b in1=%h in2=%h br=%b ill=%b want zero",
                     control_o, in1_o, in2_o, is_branch_o, illegal_o);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_rtype();
        logic [2:0] f3s   [5] = '{3'd0, 3'd0, 3'd4, 3'd6, 3'd7};
        logic       f7s   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0] codes [5] = '{4'b0010, 4'b0110, 4'b0100,
                                  4'b0001, 4'b0000};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            set_fields(2'd2, f3s[i], f7s[i], 1'b0,
                       32'h0000_00F0, 32'h0000_000F, 32'h0);
            tick();
            total++;
            if (out_valid !== 1'b1 || control_o !== codes[i]
                || illegal_o !== 1'b0 || in1_o !== 32'hF0
                || in2_o !== 32'h0F) begin
                bad++;
                $display("FAIL rtype[%0d] v=%b ctl=%b ill=%b in1=%h in2=%h want v=1 ctl=%b ill=0 in1=f0 in2=0f",
                         i, out_valid, control_o, illegal_o, in1_o,
                         in2_o, codes[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rtype_drain got=%b want=0", out_valid);
        end
    endtask

    task automatic test_itype_illegal();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_fields(2'd3, 3'd0, 1'b1, 1'b1, 32'h55, 32'h77, 32'hFFFF_FFFC);
        tick();
        total++;
        if (control_o !== 4'b0010 || in2_o !== 32'hFFFF_FFFC
            || illegal_o !== 1'b0 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL itype_add ctl=%b in2=%h ill=%b want 0010 fffffffc 0",
                     control_o, in2_o, illegal_o);
        end
        funct3 = 3'd1;
        tick();
        total++;
        if (control_o !== 4'b1111 || illegal_o !== 1'b1
            || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL itype_illegal ctl=%b ill=%b want 1111 1",
                     control_o, illegal_o);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_branch();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_fields(2'd1, 3'd3, 1'b0, 1'b0, 32'h1234, 32'h1234, 32'h9);
        tick();
        total++;
        if (control_o !== 4'b0110 || is_branch_o !== 1'b1
            || in1_o !== 32'h1234 || in2_o !== 32'h1234) begin
            bad++;
            $display("FAIL branch ctl=%b br=%b in1=%h in2=%h want 0110 1 1234 1234",
                     control_o, is_branch_o, in1_o, in2_o);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_fields(2'd2, 3'd0, 1'b0, 1'b0, 32'd1, 32'd0, 32'd0);
        tick();
        rs1_data = 32'd2;
        tick();
        total++;
        if (in_ready !== 1'b0 || in1_o !== 32'd1) begin
            bad++;
            $display("FAIL bp_full rdy=%b in1=%h want 0 1", in_ready, in1_o);
        end
        rs1_data = 32'd3;
        tick();
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || in1_o !== 32'd1) begin
            bad++;
            $display("FAIL bp_hold rdy=%b v=%b in1=%h want 0 1 1",
                     in_ready, out_valid, in1_o);
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b1 || in1_o !== 32'd2) begin
            bad++;
            $display("FAIL bp_second v=%b in1=%h want 1 2", out_valid, in1_o);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || in1_o !== 32'd3) begin
            bad++;
            $display("FAIL bp_third v=%b in1=%h want 1 3", out_valid, in1_o);
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_drain v=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_fields(2'd0, 3'd0, 1'b0, 1'b0, 32'd10, 32'd0, 32'd0);
        tick();
        rs1_data = 32'd11;
        tick();
        rs1_data = 32'd12;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_full v=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        rs1_data = 32'd13;
        tick();
        rs1_data = 32'd14;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b1;
        rs1_data = 32'd15;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_one v=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL flush_ghost[%0d] v=%b in1=%h want v=0",
                         i, out_valid, in1_o);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(31) == 0);
            set_fields(2'($urandom_range(3)), 3'($urandom_range(7)),
                       1'($urandom_range(1)), 1'($urandom_range(1)),
                       $urandom, $urandom, $urandom);
            tick();
            total++;
            if (in_ready !== m_ready
                || out_valid !== (exp_q.size() > 0)) begin
                bad++;
                $display("FAIL rand_hs[%0d] rdy=%b v=%b want rdy=%b v=%b",
                         n, in_ready, out_valid, m_ready, exp_q.size() > 0);
            end else if (exp_q.size() > 0) begin
                total++;
                if (control_o !== exp_q[0].code || in1_o !== exp_q[0].a
                    || in2_o !== exp_q[0].b || is_branch_o !== exp_q[0].br
                    || illegal_o !== exp_q[0].ill) begin
                    bad++;
                    $display("FAIL rand_data[%0d] got %b/%h/%h/%b/%b want %b/%h/%h/%b/%b",
                             n, control_o, in1_o, in2_o, is_branch_o,
                             illegal_o, exp_q[0].code, exp_q[0].a,
                             exp_q[0].b, exp_q[0].br, exp_q[0].ill);
                end
            end
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_fields(2'd0, 3'd0, 1'b0, 1'b0, 32'd21, 32'd22, 32'd0);
        tick();
        tick();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || control_o !== 4'b0000
            || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL async_reset v=%b ctl=%b rdy=%b want 0 0000 0",
                     out_valid, control_o, in_ready);
        end
        exp_q.delete();
        m_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_release rdy=%b v=%b want 1 0", in_ready, out_valid);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_fields(2'd0, 3'd5, 1'b1, 1'b1, 32'd5, 32'd9, 32'd7);
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || control_o !== 4'b0010
            || in1_o !== 32'd5 || in2_o !== 32'd7) begin
            bad++;
            $display("FAIL post_rst_add v=%b ctl=%b in1=%h in2=%h want 1 0010 5 7",
                     out_valid, control_o, in1_o, in2_o);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_rst_drain v=%b want 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_itype_illegal();
        test_branch();
        test_backpressure();
        test_flush();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
